rr_select_logic: RTL

//  Parametrised issue-queue select stage for N issue classes x G grants each.
//  Per-class rotating (round-robin) priority replaces fixed-index picking.
//  An optional per-entry starvation guard forces long-waiting entries to win.

---
 rtl/rr_select_logic.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rr_select_logic.sv
// Issue-queue select: per-class round-robin picks up to GRANT_NUM ready entries per cycle, same-cycle grants.
// Latency 0 for grants, pointer/counter effect next cycle; stall masks grants and freezes state.
// Optional starvation guard (RSD_SELECT_STARVATION_GUARD_EN) lets saturated-wait entries win first.
module rr_select_logic #(
  parameter int ENTRY_NUM    = 16,
  parameter int CLASS_NUM    = 4,
  parameter int GRANT_NUM    = 2,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               flush,
  input  logic                                               stall,
  input  logic [ENTRY_NUM-1:0]                               opReady,
  input  logic [CLASS_NUM*ENTRY_NUM-1:0]                     issueReq,
  output logic [CLASS_NUM*GRANT_NUM-1:0]                     selected,
  output logic [CLASS_NUM*GRANT_NUM*$clog2(ENTRY_NUM)-1:0]   selectedPtr,
  output logic [CLASS_NUM*ENTRY_NUM-1:0]                     selectedVector,
  output logic [CLASS_NUM*$clog2(ENTRY_NUM)-1:0]             rrPtrDbg
);

  localparam int IW = $clog2(ENTRY_NUM);

  if (ENTRY_NUM < 4 || (ENTRY_NUM & (ENTRY_NUM - 1)) != 0) begin : gEntryChk
    $error("ENTRY_NUM must be a power of two and at least 4");
  end
  if (GRANT_NUM < 1 || GRANT_NUM > ENTRY_NUM) begin : gGrantChk
    $error("GRANT_NUM out of range");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gStarveChk
    $error("STARVE_LIMIT out of range");
  end

  logic [CLASS_NUM-1:0][ENTRY_NUM-1:0]          req;
  logic [ENTRY_NUM-1:0]                         anyReq;
  logic [CLASS_NUM-1:0][IW-1:0]                 rrPtr;
  logic [CLASS_NUM-1:0][IW-1:0]                 rrPtrNext;
  logic [CLASS_NUM-1:0][GRANT_NUM-1:0]          gntVld;
  logic [CLASS_NUM-1:0][GRANT_NUM-1:0][IW-1:0]  gntIdx;
  logic [CLASS_NUM-1:0][ENTRY_NUM-1:0]          gntVec;
  logic [CLASS_NUM-1:0]                         rrAny;
  logic [CLASS_NUM-1:0][IW-1:0]                 rrLast;
  logic                                         outEn;

  // An entry asking for several classes competes only in its lowest class.
  always_comb begin
    req    = '0;
    anyReq = '0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      req[c] = issueReq[c*ENTRY_NUM +: ENTRY_NUM] & opReady & ~anyReq;
      anyReq = anyReq | req[c];
    end
  end

`ifdef RSD_SELECT_STARVATION_GUARD_EN
  logic [ENTRY_NUM-1:0][3:0] starveCnt;
  logic [ENTRY_NUM-1:0]      starved;
  logic [ENTRY_NUM-1:0]      gntAll;

  always_comb begin
    gntAll  = '0;
    starved = '0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      gntAll = gntAll | gntVec[c];
    end
    for (int e = 0; e < ENTRY_NUM; e++) begin
      starved[e] = (starveCnt[e] == 4'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      starveCnt <= '0;
    end else if (!stall) begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        if (!anyReq[e] || gntAll[e]) begin
          starveCnt[e] <= '0;
        end else if (starveCnt[e] != 4'(STARVE_LIMIT)) begin
          starveCnt[e] <= starveCnt[e] + 4'd1;
        end
      end
    end
  end
`endif

  always_comb begin
    int               n;
    logic [IW-1:0]    idx;
    n      = 0;
    idx    = '0;
    gntVld = '0;
    gntIdx = '0;
    gntVec = '0;
    rrAny  = '0;
    rrLast = '0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      n = 0;
`ifdef RSD_SELECT_STARVATION_GUARD_EN
      // Starved entries go first in plain ascending order, ignoring the pointer.
      for (int e = 0; e < ENTRY_NUM; e++) begin
        if (req[c][e] && starved[e] && n < GRANT_NUM) begin
          for (int g = 0; g < GRANT_NUM; g++) begin
            if (g == n) begin
              gntVld[c][g] = 1'b1;
              gntIdx[c][g] = IW'(e);
            end
          end
          gntVec[c][e] = 1'b1;
          n = n + 1;
        end
      end
`endif
      for (int k = 0; k < ENTRY_NUM; k++) begin
        idx = rrPtr[c] + IW'(k);
        if (req[c][idx] && !gntVec[c][idx] && n < GRANT_NUM) begin
          for (int g = 0; g < GRANT_NUM; g++) begin
            if (g == n) begin
              gntVld[c][g] = 1'b1;
              gntIdx[c][g] = idx;
            end
          end
          gntVec[c][idx] = 1'b1;
          rrAny[c]       = 1'b1;
          rrLast[c]      = idx;
          n = n + 1;
        end
      end
    end
  end

  // Only round-robin grants move the pointer; starved-only grants leave it put.
  always_comb begin
    rrPtrNext = rrPtr;
    for (int c = 0; c < CLASS_NUM; c++) begin
      if (rrAny[c]) begin
        rrPtrNext[c] = rrLast[c] + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rrPtr <= '0;
    end else if (!stall) begin
      rrPtr <= rrPtrNext;
    end
  end

  assign outEn          = ~(rst | flush | stall);
  assign selected       = outEn ? gntVld : '0;
  assign selectedPtr    = outEn ? gntIdx : '0;
  assign selectedVector = outEn ? gntVec : '0;
  assign rrPtrDbg       = rrPtr;

endmodule
